// File: rtl/axi4s_uart_tx_arbiter.sv
// axi4s_uart_tx_arbiter: round-robin packet arbiter that frames AXI4-Stream byte sources
// as 7E, id, byte-stuffed payload, 7E onto a single UART TX byte stream.
module axi4s_uart_tx_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_SRC-1:0]   s_tvalid,
  output logic [NUM_SRC-1:0]   s_tready,
  input  logic [8*NUM_SRC-1:0] s_tdata,
  input  logic [NUM_SRC-1:0]   s_tlast,
  input  logic [NUM_SRC-1:0]   src_enable,
  output logic                 tx_byte_tvalid,
  input  logic                 tx_byte_tready,
  output logic [7:0]           tx_byte_tdata,
  output logic                 busy,
  output logic [2:0]           active_src
);
  typedef enum logic [2:0] {IDLE, SOF, ID, DATA, ESC, EOF} state_t;
  state_t state, state_n;
  logic [2:0] last_grant, grant;
  logic [NUM_SRC-1:0] req, rot;
  logic found, slot_free, load, cur_valid, cur_last, src_hs, is_esc, esc_last;
  logic [7:0] load_byte, cur_data, esc_byte;
  assign slot_free = !tx_byte_tvalid || tx_byte_tready;
  assign req = s_tvalid & src_enable;
  assign busy = state != IDLE;
  assign is_esc = cur_data == 8'h7E || cur_data == 8'h7D;
  assign src_hs = state == DATA && slot_free && cur_valid;
  // rotate requests so bit 0 is the source just after the last grant
  always_comb begin
    rot = NUM_SRC'({req, req} >> (int'(last_grant) + 1));
    grant = '0;
    found = 1'b0;
    for (int j = NUM_SRC - 1; j >= 0; j--)
      if (rot[j]) begin
        found = 1'b1;
        grant = 3'((int'(last_grant) + 1 + j) % NUM_SRC);
      end
  end
  always_comb begin
    cur_valid = 1'b0;
    cur_last = 1'b0;
    cur_data = '0;
    s_tready = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (active_src == 3'(i)) begin
        cur_valid = s_tvalid[i];
        cur_last = s_tlast[i];
        cur_data = s_tdata[8*i +: 8];
        s_tready[i] = state == DATA && slot_free;
      end
  end
  always_comb begin
    state_n = state;
    load = 1'b0;
    load_byte = 8'h00;
    case (state)
      IDLE: state_n = found ? SOF : IDLE;
      SOF: if (slot_free) begin
        load = 1'b1;
        load_byte = 8'h7E;
        state_n = ID;
      end
      ID: if (slot_free) begin
        load = 1'b1;
        load_byte = {5'b0, active_src};
        state_n = DATA;
      end
      DATA: if (src_hs) begin
        load = 1'b1;
        load_byte = is_esc ? 8'h7D : cur_data;
        state_n = is_esc ? ESC : (cur_last ? EOF : DATA);
      end
      ESC: if (slot_free) begin
        load = 1'b1;
        load_byte = esc_byte;
        state_n = esc_last ? EOF : DATA;
      end
      EOF: if (slot_free) begin
        load = 1'b1;
        load_byte = 8'h7E;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      tx_byte_tvalid <= 1'b0;
      tx_byte_tdata <= 8'h00;
      active_src <= '0;
      last_grant <= 3'(NUM_SRC - 1);
      esc_byte <= 8'h00;
      esc_last <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        tx_byte_tvalid <= 1'b1;
        tx_byte_tdata <= load_byte;
      end else if (tx_byte_tready) tx_byte_tvalid <= 1'b0;
      if (state == IDLE && found) begin
        active_src <= grant;
        last_grant <= grant;
      end
      if (src_hs && is_esc) begin
        esc_byte <= cur_data ^ 8'h20;
        esc_last <= cur_last;
      end
    end
endmodule

// File: tb/tb_axi4s_uart_tx_arbiter.sv
// tb_axi4s_uart_tx_arbiter: randomized scenarios checked against a frame-level model of the
// byte stream (SOF, id, stuffed payload, EOF) built from queued source packets.
module tb_axi4s_uart_tx_arbiter;
  localparam int N = 4;
  logic aclk = 1'b0, aresetn;
  logic [N-1:0] s_tvalid, s_tready, s_tlast, src_enable;
  logic [8*N-1:0] s_tdata;
  logic tx_byte_tvalid, tx_byte_tready, busy;
  logic [7:0] tx_byte_tdata;
  logic [2:0] active_src;
  int n_cmp = 0, n_bad = 0, cyc = 0, first_v = -1, last_v = -1, valid_cnt = 0;
  logic [8:0] src_q[N][$];
  logic [7:0] out_q[$], exp_q[$];
  bit rand_bp = 0, stall_prev = 0;
  logic [7:0] prev_data = 8'h00;

  axi4s_uart_tx_arbiter #(.NUM_SRC(N)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .src_enable(src_enable),
    .tx_byte_tvalid(tx_byte_tvalid), .tx_byte_tready(tx_byte_tready),
    .tx_byte_tdata(tx_byte_tdata), .busy(busy), .active_src(active_src));

  always #5 aclk = ~aclk;

  // source queues, sink readiness, output capture and stall-stability checks
  initial begin
    logic [N-1:0] hs;
    logic thx;
    logic [7:0] d;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; tx_byte_tready = 1'b1;
    forever begin
      @(negedge aclk);
      hs = s_tvalid & s_tready;
      thx = tx_byte_tvalid && tx_byte_tready;
      d = tx_byte_tdata;
      if (stall_prev) begin
        n_cmp++;
        if (tx_byte_tvalid !== 1'b1 || d !== prev_data) begin
          n_bad++;
          $display("FAIL stall_stable: tvalid=%b tdata=%h, required 1 %h", tx_byte_tvalid, d, prev_data);
        end
      end
      if (tx_byte_tvalid && !tx_byte_tready) begin
        n_cmp++;
        if (s_tready !== '0) begin
          n_bad++;
          $display("FAIL stall_tready: s_tready=%b, required 0000", s_tready);
        end
      end
      stall_prev = tx_byte_tvalid && !tx_byte_tready && aresetn;
      prev_data = d;
      if (tx_byte_tvalid) begin
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        valid_cnt++;
      end
      if (thx) out_q.push_back(d);
      @(posedge aclk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        s_tvalid[i] = src_q[i].size() > 0;
        {s_tlast[i], s_tdata[8*i +: 8]} = s_tvalid[i] ? src_q[i][0] : 9'h0;
      end
      tx_byte_tready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [7:0] rnd_byte(bit esc_ok);
    logic [7:0] r = 8'($urandom);
    if (esc_ok && $urandom_range(0, 3) == 0) r = $urandom_range(0, 1) ? 8'h7E : 8'h7D;
    if (!esc_ok && (r == 8'h7E || r == 8'h7D)) r = 8'h55;
    return r;
  endfunction

  task automatic push_pkt(input int src, input logic [7:0] pl[$]);
    foreach (pl[k]) src_q[src].push_back({k == pl.size() - 1, pl[k]});
  endtask

  task automatic model_frame(input int id, input logic [7:0] pl[$]);
    exp_q.push_back(8'h7E);
    exp_q.push_back(8'(id));
    foreach (pl[k])
      if (pl[k] == 8'h7E || pl[k] == 8'h7D) begin
        exp_q.push_back(8'h7D);
        exp_q.push_back(pl[k] ^ 8'h20);
      end else exp_q.push_back(pl[k]);
    exp_q.push_back(8'h7E);
  endtask

  task automatic rnd_pkt(input int src, input int len, input bit esc_ok);
    logic [7:0] pl[$];
    for (int k = 0; k < len; k++) pl.push_back(rnd_byte(esc_ok));
    push_pkt(src, pl);
    model_frame(src, pl);
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) src_q[i].delete();
    out_q.delete(); exp_q.delete();
    stall_prev = 0; first_v = -1; last_v = -1; valid_cnt = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0; rand_bp = 0; src_enable = '1;
    flush();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge aclk);
      if (out_q.size() >= exp_q.size() && !busy && !tx_byte_tvalid) ok = 1;
    end
    repeat (8) @(negedge aclk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (tx_byte_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b, required 0", tx_byte_tvalid); end
    if (tx_byte_tdata !== 8'h00) begin n_bad++; $display("FAIL rst_tdata: got %h, required 00", tx_byte_tdata); end
    if (s_tready !== '0) begin n_bad++; $display("FAIL rst_tready: got %b, required 0000", s_tready); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (active_src !== 3'd0) begin n_bad++; $display("FAIL rst_active: got %0d, required 0", active_src); end
  endtask

  task automatic test_single();
    logic [7:0] pl[$] = '{8'h11, 8'h22};
    int t0 = -1;
    bit ok;
    do_reset();
    push_pkt(2, pl);
    model_frame(2, pl);
    for (int t = 0; t < 20 && t0 < 0; t++) begin
      @(negedge aclk);
      if (s_tvalid[2]) t0 = cyc;
    end
    for (int t = 0; t < 20 && first_v < 0; t++) @(negedge aclk);
    n_cmp++;
    if (first_v - t0 !== 2) begin n_bad++; $display("FAIL single_latency: got %0d cycles, required 2", first_v - t0); end
    wait_done(ok);
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL single_done: timed out, required completion"); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b, required 0", busy); end
    if (active_src !== 3'd2) begin n_bad++; $display("FAIL single_active: got %0d, required 2", active_src); end
    n_cmp++;
    if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_len: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL single_byte%0d: got %h, required %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_escape();
    logic [7:0] pl[$] = '{8'h7E, 8'h7D};
    bit ok;
    do_reset();
    push_pkt(0, pl);
    model_frame(0, pl);
    rnd_pkt(1, 6, 1);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL escape_done: timed out, required completion"); end
    if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL escape_len: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL escape_byte%0d: got %h, required %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    do_reset();
    for (int i = 0; i < N; i++) rnd_pkt(i, 1, 0);
    rnd_pkt(0, 1, 0);
    wait_done(ok);
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL rr_done: timed out, required completion"); end
    if (valid_cnt != 20) begin n_bad++; $display("FAIL rr_valid_cycles: got %0d, required 20", valid_cnt); end
    if (last_v - first_v + 1 != 24) begin n_bad++; $display("FAIL rr_span: got %0d cycles, required 24", last_v - first_v + 1); end
    if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rr_len: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL rr_byte%0d: got %h, required %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    rand_bp = 1;
    for (int r = 0; r < 3; r++) begin
      out_q.delete(); exp_q.delete();
      for (int i = 0; i < N; i++) rnd_pkt(i, r == 0 ? 3 : $urandom_range(1, 5), 1);
      wait_done(ok);
      n_cmp += 2;
      if (!ok) begin n_bad++; $display("FAIL bp_done%0d: timed out, required completion", r); end
      if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bp_len%0d: got %0d bytes, required %0d", r, out_q.size(), exp_q.size()); end
      foreach (exp_q[k]) if (k < out_q.size()) begin
        n_cmp++;
        if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL bp_byte%0d_%0d: got %h, required %h", r, k, out_q[k], exp_q[k]); end
      end
    end
    rand_bp = 0;
  endtask

  task automatic test_enable();
    logic [7:0] p0[$] = '{8'hA0}, p2[$] = '{8'hA2};
    bit ok;
    do_reset();
    src_enable = 4'b1010;
    push_pkt(0, p0);
    rnd_pkt(1, 3, 1);
    push_pkt(2, p2);
    rnd_pkt(3, 1, 1);
    for (int t = 0; t < 50 && out_q.size() < 2; t++) @(negedge aclk);
    src_enable = 4'b1000;
    wait_done(ok);
    n_cmp += 4;
    if (!ok) begin n_bad++; $display("FAIL en_done: timed out, required completion"); end
    if (src_q[0].size() != 1) begin n_bad++; $display("FAIL en_src0_left: got %0d bytes, required 1", src_q[0].size()); end
    if (src_q[2].size() != 1) begin n_bad++; $display("FAIL en_src2_left: got %0d bytes, required 1", src_q[2].size()); end
    if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL en_len: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL en_byte%0d: got %h, required %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rnd_pkt(2, 5, 0);
    for (int t = 0; t < 50 && out_q.size() < 2; t++) @(negedge aclk);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1;
    n_cmp += 3;
    if (tx_byte_tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tvalid: got %b, required 0", tx_byte_tvalid); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
    if (s_tready !== '0) begin n_bad++; $display("FAIL mid_rst_tready: got %b, required 0000", s_tready); end
    flush();
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;
    rnd_pkt(0, 2, 1);
    rnd_pkt(2, 2, 1);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_bad++; $display("FAIL mid_done: timed out, required completion"); end
    if (out_q.size() != exp_q.size()) begin n_bad++; $display("FAIL mid_len: got %0d bytes, required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[k]) if (k < out_q.size()) begin
      n_cmp++;
      if (out_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL mid_byte%0d: got %h, required %h", k, out_q[k], exp_q[k]); end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    src_enable = '1;
    test_reset();
    test_single();
    test_escape();
    test_round_robin();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
